alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port op  input  4  operation code, sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A, two's complement, sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B, two's complement, sampled with start.
REQ-008 SHALL have port res  output  WIDTH+1  registered result; bit WIDTH is carry/borrow or zero.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when res and flags become valid.
REQ-011 SHALL have port flags  output  5  {dz, ill, ovf, neg, zero}, registered with res.

Function
REQ-012 SHALL decode op: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a by b[4:0], 7 SHR logical a by b[4:0], 8 MUL unsigned, 9 DIV unsigned quotient, 10 MOD unsigned remainder, 11-15 illegal.
REQ-013 SHALL implement states IDLE, CALC, DONE; IDLE->DONE on start with op 0-7, 11-15, or op 9/10 with b==0; IDLE->CALC on start with op 8-10 otherwise; CALC->DONE after exactly WIDTH iteration cycles; DONE->IDLE unconditionally.
REQ-014 SHALL assert done only in DONE; single-cycle ops give done on the first edge after the accepting edge (latency 1); MUL/DIV/MOD give done WIDTH+1 cycles after the accepting edge.
REQ-015 SHALL ignore start while busy, including in DONE (no back-to-back acceptance; minimum issue interval 2 cycles).
REQ-016 SHALL latch a, b, op at acceptance; operand changes during CALC SHALL not affect the result.
REQ-017 SHALL hold res and flags stable from done until the next done.
REQ-018 ADD/SUB: res = full WIDTH+1 sum/difference of zero-extended operands (res[WIDTH] = carry out / borrow); ovf = signed overflow of the WIDTH-bit result.
REQ-019 Logic/shift ops: res[WIDTH] = 0 except SHL, where res[WIDTH] = last bit shifted out (0 if shift 0); shift amounts >= WIDTH give res[WIDTH-1:0]=0; ovf = 0.
REQ-020 MUL: shift-add, one partial product per CALC cycle; res = {0, low WIDTH bits of product}; ovf = 1 iff high WIDTH bits nonzero.
REQ-021 DIV/MOD: restoring division, one quotient bit per CALC cycle; res = {0, quotient} or {0, remainder}; ovf = 0.
REQ-022 DIV/MOD with b==0: res = {0, all ones} for DIV, {0, a} for MOD; dz = 1; latency 1.
REQ-023 Illegal op: res = 0, ill = 1, latency 1; all other flags 0 except zero = 1.
REQ-024 zero = (res[WIDTH-1:0] == 0); neg = res[WIDTH-1]; dz and ill are 0 for all other cases.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, res = 0, flags = 0, busy = 0, done = 0, and clear iteration counter and internal accumulators.
REQ-026 Reset asserted during CALC SHALL abort the operation with no done pulse; first start after rst_n deassertion SHALL be accepted normally.
REQ-027 start SHALL be ignored on the edge coincident with rst_n low.

Verification
REQ-028 WIDTH=16, ADD a=0x7FFF b=0x0001 -> done at +1 cycle, res=0x08000, ovf=1, neg=1, zero=0.
REQ-029 WIDTH=16, SUB a=0x0003 b=0x0005 -> res=0x1FFFE (borrow set), neg=1, ovf=0.
REQ-030 WIDTH=16, MUL a=0x0100 b=0x0101 -> busy 17 cycles, done at +17, res=0x00100, ovf=1; start pulses during CALC ignored.
REQ-031 WIDTH=16, DIV a=100 b=7 -> res=14 at +17; MOD same operands -> res=2; DIV a=5 b=0 -> res=0x0FFFF, dz=1 at +1.
REQ-032 Reset pulse at cycle 8 of a MUL -> busy=0, res=0, no done; subsequent ADD 2+3 -> res=5 at +1.
REQ-033 op=12 -> res=0, ill=1, zero=1; repeat REQ-028..031 with WIDTH=8 scaled operands to confirm parametrisation.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide, with result flags.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   res,
  output logic             busy,
  output logic             done,
  output logic [4:0]       flags
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Handshake: start is accepted only on a rising edge where the FSM is IDLE;
  // done is a one-cycle pulse and res/flags hold until the next done.
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH:0]     res_q, res_d;
  logic [4:0]         flags_q, flags_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sc_res;
  logic               sc_ovf, sc_dz, sc_ill;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic               go_calc;

  function automatic logic [4:0] mk_flags(input logic [WIDTH:0] r, input logic dz,
                                          input logic ill, input logic ovf);
    mk_flags = {dz, ill, ovf, r[WIDTH-1], (r[WIDTH-1:0] == '0)};
  endfunction

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_dz  = 1'b0;
    sc_ill = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = {1'b0, a} + {1'b0, b};
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = {1'b0, a} - {1'b0, b};
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_res = {1'b0, a & b};
      OP_OR:  sc_res = {1'b0, a | b};
      OP_XOR: sc_res = {1'b0, a ^ b};
      OP_NOT: sc_res = {1'b0, ~a};
      // Bit WIDTH of the widened shift is exactly the last bit shifted out.
      OP_SHL: sc_res = {1'b0, a} << b[4:0];
      OP_SHR: sc_res = {1'b0, a >> b[4:0]};
      OP_DIV: begin
        sc_res = {1'b0, {WIDTH{1'b1}}};
        sc_dz  = 1'b1;
      end
      OP_MOD: begin
        sc_res = {1'b0, a};
        sc_dz  = 1'b1;
      end
      OP_MUL: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // One multiply step: conditionally add B into the upper half, shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // One restoring-divide step; the remainder always stays below B, so bit
  // WIDTH of the difference is a valid borrow indicator.
  always_comb begin
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    div_ge   = ~rem_diff[WIDTH];
    div_next = {(div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end

  assign go_calc = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          b_d   = b;
          cnt_d = '0;
          if (go_calc) begin
            acc_d   = {{WIDTH{1'b0}}, a};
            state_d = CALC;
          end else begin
            res_d   = sc_res;
            flags_d = mk_flags(sc_res, sc_dz, sc_ill, sc_ovf);
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        acc_d = (op_q == OP_MUL) ? mul_next : div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          done_d  = 1'b1;
          state_d = DONE;
          if (op_q == OP_MUL) begin
            res_d   = {1'b0, mul_next[WIDTH-1:0]};
            flags_d = mk_flags({1'b0, mul_next[WIDTH-1:0]}, 1'b0, 1'b0,
                               |mul_next[2*WIDTH-1:WIDTH]);
          end else if (op_q == OP_DIV) begin
            res_d   = {1'b0, div_next[WIDTH-1:0]};
            flags_d = mk_flags({1'b0, div_next[WIDTH-1:0]}, 1'b0, 1'b0, 1'b0);
          end else begin
            res_d   = {1'b0, div_next[2*WIDTH-1:WIDTH]};
            flags_d = mk_flags({1'b0, div_next[2*WIDTH-1:WIDTH]}, 1'b0, 1'b0, 1'b0);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign res   = res_q;
  assign flags = flags_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16 and WIDTH=8 with hand-computed results.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, start8 = 1'b0;
  logic [3:0]  op16 = '0, op8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [16:0] res16;
  logic [8:0]  res8;
  logic        busy16, busy8, done16, done8;
  logic [4:0]  flags16, flags8;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .res(res16), .busy(busy16), .done(done16), .flags(flags16)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .res(res8), .busy(busy8), .done(done8), .flags(flags8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op; latency counts edges from the accepting edge to done.
  task automatic run16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [16:0] er, input logic [4:0] ef, input int elat,
                       input bit poke, input string tag);
    int lat;
    int nbusy;
    @(negedge clk);
    op16 = o; a16 = x; b16 = y; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = poke;
    lat = 1;
    nbusy = 0;
    while (!done16 && lat < 64) begin
      if (busy16) nbusy++;
      if (poke) begin
        op16 = 4'd0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (busy16) nbusy++;
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_cycles"}, nbusy, elat);
    check({tag, " res"}, res16, er);
    check({tag, " flags"}, flags16, ef);
    @(posedge clk); #1;
    start16 = 1'b0;
    check({tag, " done_pulse"}, done16, 1'b0);
    check({tag, " idle_after"}, busy16, 1'b0);
    check({tag, " res_hold"}, res16, er);
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [8:0] er, input logic [4:0] ef, input int elat,
                      input string tag);
    int lat;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " res"}, res8, er);
    check({tag, " flags"}, flags8, ef);
    @(posedge clk); #1;
    check({tag, " idle_after"}, busy8, 1'b0);
  endtask

  initial begin
    bit saw_done;

    repeat (2) @(posedge clk);
    #1;
    check("rst res16", res16, 17'h0);
    check("rst flags16", flags16, 5'h0);
    check("rst busy16", busy16, 1'b0);
    check("rst done16", done16, 1'b0);
    check("rst res8", res8, 9'h0);
    check("rst busy8", busy8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // flags order: {dz, ill, ovf, neg, zero}
    run16(4'd0, 16'h7FFF, 16'h0001, 17'h08000, 5'b00110, 1, 1'b0, "add_ovf");
    run16(4'd1, 16'h0003, 16'h0005, 17'h1FFFE, 5'b00010, 1, 1'b0, "sub_borrow");
    run16(4'd8, 16'h0100, 16'h0101, 17'h00100, 5'b00100, 17, 1'b1, "mul_ovf");
    run16(4'd9, 16'd100, 16'd7, 17'd14, 5'b00000, 17, 1'b1, "div");
    run16(4'd10, 16'd100, 16'd7, 17'd2, 5'b00000, 17, 1'b0, "mod");
    run16(4'd9, 16'd5, 16'd0, 17'h0FFFF, 5'b10010, 1, 1'b0, "div_zero");
    run16(4'd10, 16'd5, 16'd0, 17'h00005, 5'b10000, 1, 1'b0, "mod_zero");
    run16(4'd12, 16'h1234, 16'h5678, 17'h0, 5'b01001, 1, 1'b0, "illegal");
    run16(4'd0, 16'hFFFF, 16'h0001, 17'h10000, 5'b00001, 1, 1'b0, "add_carry");
    run16(4'd1, 16'h8000, 16'h0001, 17'h07FFF, 5'b00100, 1, 1'b0, "sub_ovf");
    run16(4'd2, 16'hF0F0, 16'hFF00, 17'h0F000, 5'b00010, 1, 1'b0, "and");
    run16(4'd3, 16'h1234, 16'h4321, 17'h05335, 5'b00000, 1, 1'b0, "or");
    run16(4'd4, 16'hAAAA, 16'hAAAA, 17'h00000, 5'b00001, 1, 1'b0, "xor");
    run16(4'd5, 16'h00FF, 16'h0000, 17'h0FF00, 5'b00010, 1, 1'b0, "not");
    run16(4'd6, 16'h8001, 16'h0001, 17'h10002, 5'b00000, 1, 1'b0, "shl1");
    run16(4'd6, 16'h8001, 16'h0000, 17'h08001, 5'b00010, 1, 1'b0, "shl0");
    run16(4'd6, 16'h0001, 16'h0010, 17'h10000, 5'b00001, 1, 1'b0, "shl16");
    run16(4'd7, 16'h8000, 16'h000F, 17'h00001, 5'b00000, 1, 1'b0, "shr15");
    run16(4'd7, 16'h8000, 16'h0014, 17'h00000, 5'b00001, 1, 1'b0, "shr20");
    run16(4'd8, 16'hFFFF, 16'hFFFF, 17'h00001, 5'b00100, 17, 1'b0, "mul_max");
    run16(4'd8, 16'd3, 16'd5, 17'd15, 5'b00000, 17, 1'b0, "mul_small");
    run16(4'd9, 16'hFFFF, 16'h0010, 17'h00FFF, 5'b00000, 17, 1'b0, "div_big");
    run16(4'd10, 16'hFFFF, 16'h0010, 17'h0000F, 5'b00000, 17, 1'b0, "mod_big");

    // Reset in the middle of a multiply.
    @(negedge clk);
    op16 = 4'd8; a16 = 16'h0100; b16 = 16'h0101; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy16, 1'b0);
    check("midrst res", res16, 17'h0);
    check("midrst flags", flags16, 5'h0);
    check("midrst done", done16, 1'b0);
    op16 = 4'd0; a16 = 16'd1; b16 = 16'd1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    check("start_in_reset busy", busy16, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done16) saw_done = 1'b1;
    end
    check("midrst no_done", saw_done, 1'b0);
    run16(4'd0, 16'd2, 16'd3, 17'd5, 5'b00000, 1, 1'b0, "add_after_rst");

    run8(4'd0, 8'h7F, 8'h01, 9'h080, 5'b00110, 1, "w8 add_ovf");
    run8(4'd1, 8'h03, 8'h05, 9'h1FE, 5'b00010, 1, "w8 sub_borrow");
    run8(4'd8, 8'h10, 8'h11, 9'h010, 5'b00100, 9, "w8 mul_ovf");
    run8(4'd9, 8'd100, 8'd7, 9'd14, 5'b00000, 9, "w8 div");
    run8(4'd10, 8'd100, 8'd7, 9'd2, 5'b00000, 9, "w8 mod");
    run8(4'd9, 8'd5, 8'd0, 9'h0FF, 5'b10010, 1, "w8 div_zero");
    run8(4'd12, 8'h12, 8'h34, 9'h000, 5'b01001, 1, "w8 illegal");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
